// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop processes
// WIDTH-bit operands LSB first, one bit per clock, with a start/done handshake.
module serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             c;
   logic             s;
   logic             c_next;

   // Returns {carry, sum} of a single full-adder slice.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
   endfunction

   always_comb begin
      {c_next, s} = full_add(opa[0], opb[0], c);
   end

   assign ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         c     <= 1'b0;
         acc   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
               if (start) begin
                  opa   <= a;
                  opb   <= sub ? ~b : b;
                  c     <= sub;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               opa <= opa >> 1;
               opb <= opb >> 1;
               c   <= c_next;
               acc <= {s, acc[WIDTH-1:1]};
               cnt <= cnt + CW'(1);
               // On the MSB slice, c is the carry into the MSB and c_next the carry out.
               if (cnt == LAST) begin
                  sum   <= {s, acc[WIDTH-1:1]};
                  cout  <= c_next;
                  ovf   <= c ^ c_next;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, handshake corner cases,
// random 16-bit operations and an exhaustive 4-bit sweep against an integer model.
module tb_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start16, sub16, ready16, done16, cout16, ovf16;
   logic [15:0] a16, b16, sum16;
   logic        start4, sub4, ready4, done4, cout4, ovf4;
   logic [3:0]  a4, b4, sum4;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
      .ready(ready16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
      .ready(ready4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   typedef struct {
      bit          sub;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] sum;
      bit          cout;
      bit          ovf;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Integer reference: unsigned result/carry and signed overflow from plain arithmetic.
   task automatic model(input int w, input bit s, input int ua, input int ub,
                        output int rs, output bit co, output bit ov);
      int m, sa, sb, r;
      m  = 1 << w;
      sa = (ua >= m / 2) ? ua - m : ua;
      sb = (ub >= m / 2) ? ub - m : ub;
      if (s) begin
         rs = (ua - ub + m) % m;
         co = (ua >= ub);
         r  = sa - sb;
      end else begin
         rs = (ua + ub) % m;
         co = (ua + ub) >= m;
         r  = sa + sb;
      end
      ov = (r >= m / 2) || (r < -(m / 2));
   endtask

   // Starts one 16-bit run and waits for done; lat=0 means done never came.
   task automatic run16(input bit s, input logic [15:0] x, input logic [15:0] y,
                        output int lat, output int low);
      @(negedge clk);
      sub16 = s; a16 = x; b16 = y; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      low = ready16 ? 0 : 1;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done16) begin
            lat = k;
            break;
         end
         if (!ready16) low++;
      end
   endtask

   task automatic run4(input bit s, input logic [3:0] x, input logic [3:0] y, output int lat);
      @(negedge clk);
      sub4 = s; a4 = x; b4 = y; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (done4) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      vec_t vecs[7];
      int   lat, low, rs, dcnt;
      bit   co, ov, got_done;
      logic [15:0] x, y;
      bit   s;

      vecs[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

      rst = 1'b1;
      start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
      start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", ready16, 1);
      check("reset_done", done16, 0);
      check("reset_sum", sum16, 0);
      check("reset_cout", cout16, 0);
      check("reset_ovf", ovf16, 0);
      check("reset_ready4", ready4, 1);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run16(vecs[i].sub, vecs[i].a, vecs[i].b, lat, low);
         check($sformatf("vec%0d_latency", i), lat, 16);
         check($sformatf("vec%0d_ready_low", i), low, 16);
         check($sformatf("vec%0d_sum", i), sum16, vecs[i].sum);
         check($sformatf("vec%0d_cout", i), cout16, vecs[i].cout);
         check($sformatf("vec%0d_ovf", i), ovf16, vecs[i].ovf);
         check($sformatf("vec%0d_ready_in_done", i), ready16, 1);
      end

      // Start held through the run with other operands, then a back-to-back start.
      @(negedge clk);
      sub16 = 1'b0; a16 = 16'h1234; b16 = 16'h4321; start16 = 1'b1;
      @(posedge clk); #1;
      a16 = 16'hAAAA; b16 = 16'h5555; sub16 = 1'b1;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done16) begin lat = k; break; end
      end
      check("b2b_first_latency", lat, 16);
      check("b2b_first_sum", sum16, 16'h5555);
      check("b2b_first_cout", cout16, 0);
      sub16 = 1'b0; a16 = 16'h0003; b16 = 16'h0004;
      @(posedge clk); #1;
      start16 = 1'b0;
      check("b2b_done_one_cycle", done16, 0);
      check("b2b_accepted", ready16, 0);
      check("b2b_sum_held", sum16, 16'h5555);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done16) begin lat = k + 1; break; end
      end
      check("b2b_second_gap", lat, 17);
      check("b2b_second_sum", sum16, 16'h0007);

      // Reset asserted on the eighth edge of a run aborts it.
      @(negedge clk);
      sub16 = 1'b0; a16 = 16'h1234; b16 = 16'h4321; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      got_done = 1'b0;
      repeat (7) begin
         @(posedge clk); #1;
         if (done16) got_done = 1'b1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_no_done", got_done, 0);
      check("abort_ready", ready16, 1);
      check("abort_done", done16, 0);
      check("abort_sum", sum16, 0);
      check("abort_cout", cout16, 0);
      check("abort_ovf", ovf16, 0);
      sub16 = 1'b0; a16 = 16'd3; b16 = 16'd4; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      check("after_abort_accept", ready16, 0);
      dcnt = 0; lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done16) begin lat = k; break; end
      end
      check("after_abort_latency", lat, 16);
      check("after_abort_sum", sum16, 7);

      // Random 16-bit operations against the integer model.
      for (int i = 0; i < 40; i++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         s = 1'($urandom);
         run16(s, x, y, lat, low);
         model(16, s, int'(x), int'(y), rs, co, ov);
         check("rand_latency", lat, 16);
         check($sformatf("rand_sum s=%0d %h,%h", s, x, y), sum16, rs);
         check($sformatf("rand_cout s=%0d %h,%h", s, x, y), cout16, co);
         check($sformatf("rand_ovf s=%0d %h,%h", s, x, y), ovf16, ov);
      end

      // Exhaustive 4-bit sweep.
      for (int sv = 0; sv < 2; sv++) begin
         for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
               run4(1'(sv), 4'(ia), 4'(ib), lat);
               model(4, 1'(sv), ia, ib, rs, co, ov);
               check($sformatf("w4_latency s=%0d %0d,%0d", sv, ia, ib), lat, 4);
               check($sformatf("w4_sum s=%0d %0d,%0d", sv, ia, ib), sum4, rs);
               check($sformatf("w4_cout s=%0d %0d,%0d", sv, ia, ib), cout4, co);
               check($sformatf("w4_ovf s=%0d %0d,%0d", sv, ia, ib), ovf4, ov);
            end
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   // Done must never coincide with ready low or last two consecutive cycles.
   logic done16_q = 1'b0;
   always @(negedge clk) begin
      if (done16 && !ready16) begin
         total++;
         $display("FAIL done_while_busy: done=1 with ready=0, expected ready=1");
      end
      if (done16 && done16_q) begin
         total++;
         $display("FAIL done_width: done high two cycles, expected one");
      end
      done16_q <= done16;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor. Each run adds or subtracts two WIDTH-bit operands one bit per clock through a single full-adder slice and a carry flip-flop. It is the sequential, width-generic successor to the combinational full adder, trading latency for area. It sits beside the ALU as the multi-cycle arithmetic option and uses a start/done handshake.

## Interface

Parameters:
- WIDTH, 16, operand/result width in bits; legal range ≥ 2.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; accepted only when ready=1.
- sub  input  1  0 = a + b, 1 = a − b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ready  output  1  high when idle and able to accept start.
- done  output  1  single-cycle pulse: result registers just updated.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; in subtract mode, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  two's-complement signed overflow.

## Operation

- States: IDLE, RUN. Internal registers:
  - operand shift registers opa and opb;
  - carry flop c;
  - partial-result shift register acc;
  - bit counter cnt, width $clog2(WIDTH).
- Reset (rst=1 at an edge) forces:
  - state IDLE, cnt=0, c=0, acc=0;
  - sum=0, cout=0, ovf=0, done=0, ready=1.
- Reset takes priority over every other input, including mid-RUN. The operation in progress is aborted with no done pulse.
- Start is accepted in IDLE when start=1 at an edge. On that edge:
  - opa←a, opb←(sub ? ~b : b), c←sub, cnt←0, state←RUN.
- Each RUN edge:
  - s = opa[0]^opb[0]^c; c ← majority(opa[0], opb[0], c);
  - opa, opb shift right one bit; acc shifts right with s entering at the MSB;
  - cnt increments.
- Final bit (edge where cnt=WIDTH−1):
  - sum←{s, acc[WIDTH−1:1]}; cout←final carry;
  - ovf←carry into MSB XOR carry out of MSB;
  - done←1; state←IDLE.
- sum, cout and ovf change only on the final-bit edge or on reset. They hold their values across IDLE and RUN until the next completion.
- start=1 while in RUN is ignored. It is neither queued nor allowed to corrupt the run.
- sub, a and b are don't-care except on the accepting edge.

## Timing

- ready = (state==IDLE); it is combinational from state. It is 0 for exactly WIDTH cycles per operation.
- Latency: start accepted at edge 0 → done=1 and results valid after edge WIDTH, for exactly one cycle.
- Back-to-back operation: ready is already 1 in the done cycle. A start in that cycle is accepted at edge WIDTH+1, giving a throughput of one result per WIDTH+1 cycles.
- done is registered, never high two consecutive cycles, and never high while ready=0.
- Reset asserted for one edge during RUN: the next cycle shows ready=1, done=0 and all results 0. A start in that cycle is accepted normally.

## Test plan

- WIDTH=16, add 0x1234+0x4321:
  - sum=0x5555, cout=0, ovf=0;
  - done high exactly after edge 16; ready low cycles 1–16.
- WIDTH=16 adds:
  - 0xFFFF+0x0001 → sum=0x0000, cout=1, ovf=0;
  - 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1.
- WIDTH=16 subtracts:
  - 7−5 → sum=0x0002, cout=1, ovf=0;
  - 5−7 → sum=0xFFFE, cout=0, ovf=0;
  - 0x8000−0x0001 → sum=0x7FFF, ovf=1.
- Start held high during RUN with different operands: first result unaffected. A start in the done cycle begins a second run, whose done follows 17 cycles after the first.
- Reset asserted at cycle 8 of a run: no done pulse; sum/cout/ovf=0 and ready=1 the next cycle. A subsequent 3+4 yields 7.
- WIDTH=4, exhaustive 16×16×2 (add/sub) against a behavioural model: sum, cout and ovf all match, with done latency 4 every time.
